piso_serializer: RTL

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/serial_pkg.sv | 11 +
 rtl/piso_serializer.sv | 74 +++++++
 2 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serializer and the downstream sequence detector bench.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with valid/ready load handshake and gapless
// back-to-back words; out, out_valid and done are registered.
module piso_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             out,
    output logic             out_valid,
    output logic             done
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    ser_state_t       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] shreg;
    logic             last_tick;
    logic             transfer;

    // The register always keeps the bit currently on out at its head position.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign last_tick  = (state == SHIFT) && (count == LAST) && shift_en;
    assign load_ready = (state == IDLE) || last_tick;
    assign transfer   = load_valid && load_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= '0;
            shreg     <= '0;
            out       <= IDLE_BIT;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= last_tick;
            if (transfer) begin
                // Taking a new word on the last tick wraps straight into it.
                state     <= SHIFT;
                count     <= '0;
                shreg     <= load_data;
                out       <= head_bit(load_data);
                out_valid <= 1'b1;
            end else if (last_tick) begin
                state     <= IDLE;
                count     <= '0;
                shreg     <= '0;
                out       <= IDLE_BIT;
                out_valid <= 1'b0;
            end else if (state == SHIFT && shift_en) begin
                count <= count + 1'b1;
                shreg <= advance(shreg);
                out   <= head_bit(advance(shreg));
            end
        end
    end

endmodule
